grf_wport_arbiter: RTL and testbench
====================================

// Module: grf_wport_arbiter
// PURPOSE
//  Shares the register file's single write port between the in-order W-stage writeback and a
//  long-latency return path (multi-cycle unit / slow memory) via a small return FIFO.
//  Keeps a per-register busy scoreboard so the D-stage can stall reads of pending registers.
//  Starvation guard stalls the pipeline so queued returns always drain.
//  Sits between W-stage/return unit and the register file write inputs (WE, A3, WD, PC4).
// PARAMETERS
//  FIFO_DEPTH    2   return-FIFO entries (power of 2, >=2)
//  MAX_OUT       4   max outstanding long-latency ops (issued, not yet written)
//  STARVE_LIMIT  3   consecutive cycles a non-empty FIFO may be denied before Hold
// PORTS
//  Clk          in   1   clock, all state updates on posedge
//  Reset        in   1   asynchronous, active-high
//  W_WE         in   1   W-stage write request
//  W_A3         in   5   W-stage destination register
//  W_WD         in   32  W-stage write data
//  W_PC4        in   32  W-stage PC+4 (trace)
//  L_Issue      in   1   long op issued this cycle (qualified by Issue_Ready)
//  L_IssueA3    in   5   destination of issued op
//  Issue_Ready  out  1   outstanding count < MAX_OUT
//  L_Valid      in   1   return data valid
//  L_A3         in   5   return destination
//  L_WD         in   32  return data
//  L_PC4        in   32  return PC+4 (trace)
//  L_Ready      out  1   FIFO can accept (= !full)
//  Q_A1, Q_A2   in   5   D-stage source registers to check
//  Q_Busy1/2    out  1   source has a pending long-latency write
//  Hold         out  1   pipeline must freeze W stage (W_WE/A3/WD held stable)
//  GRF_WE       out  1   to register file
//  GRF_A3       out  5   to register file
//  GRF_WD       out  32  to register file
//  GRF_PC4      out  32  to register file
// BEHAVIOUR
//  Reset (async): FIFO empty, busy[31:0]=0, outstanding=0, starve=0, state NORMAL.
//   While Reset high: GRF_WE=0, Hold=0, L_Ready=1, Issue_Ready=1, Q_Busy*=0.
//  Register 0: W_WE with W_A3==0 = no request; L_Issue with A3==0 ignored (no busy, no count);
//   return with L_A3==0 accepted (handshake completes) but not enqueued; $0 never busy.
//  Return handshake: transfer when L_Valid && L_Ready on posedge; entry enqueued at tail.
//   L_Ready depends only on full (not on same-cycle drain). FIFO order = return order.
//  Grant (combinational, same cycle, zero latency on W path):
//   NORMAL:  W request -> grant W; else FIFO non-empty -> grant head; else GRF_WE=0.
//   STARVED: FIFO head granted regardless of W; Hold=1; W request stays pending.
//   GRF_A3/WD/PC4 = granted source; GRF_WE=1 iff a grant exists.
//   Return path latency: >=1 cycle (accept edge, earliest write at next edge).
//  FSM:
//   NORMAL -> STARVED when starve==STARVE_LIMIT-1 and FIFO denied this cycle.
//   STARVED -> NORMAL after exactly one head drain (one cycle).
//   starve: +1 each cycle FIFO non-empty and not granted; clears on head grant or empty.
//  Scoreboard: busy[r] set on accepted issue (Issue_Ready && L_Issue, r!=0).
//   busy[r] cleared on the edge where the FIFO head with A3=r is written.
//   Same-cycle set/clear of same r: set wins.
//   Q_BusyN = busy[Q_AN] (combinational; no bypass of same-cycle write).
//   Issue to an already-busy register is illegal (D-stage stalls on Q_Busy);
//   W write to a busy register is illegal; bench flags both.
//  outstanding: +1 on accepted issue, -1 on head drain, unchanged if both.
//   Never exceeds MAX_OUT.
//  Reset mid-operation: all queued returns and busy bits discarded immediately.
// TESTING
//  1 W_WE=1,A3=5,WD=0xAA, FIFO empty -> GRF_WE=1,A3=5,WD=0xAA same cycle; Hold=0.
//  2 Issue A3=8; return WD=0x12 two cycles later, no W traffic
//    -> Q_Busy(8)=1 until GRF writes $8=0x12 one cycle after accept; busy[8]=0 after.
//  3 FIFO holds 1 entry, W_WE every cycle, STARVE_LIMIT=3
//    -> W granted 3 cycles, 4th cycle Hold=1 and FIFO head written; W granted next cycle.
//  4 Two returns back-to-back while W busy, FIFO_DEPTH=2 -> L_Ready=0 when full;
//    third return waits; drains in FIFO order.
//  5 4 issues with no returns -> Issue_Ready=0; one drain -> Issue_Ready=1 next cycle.
//  6 Async Reset mid-stream with 2 queued entries -> GRF_WE=0 and Q_Busy*=0 immediately;
//    nothing written after release.

Source files
------------

// File: rtl/grf_wport_arbiter.sv
// Register-file write-port arbiter: W-stage writeback vs. a queued long-latency return path,
// with a per-register busy scoreboard, outstanding-op limit and a starvation guard.
module grf_wport_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int MAX_OUT      = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        W_WE,
  input  logic [4:0]  W_A3,
  input  logic [31:0] W_WD,
  input  logic [31:0] W_PC4,
  input  logic        L_Issue,
  input  logic [4:0]  L_IssueA3,
  output logic        Issue_Ready,
  input  logic        L_Valid,
  input  logic [4:0]  L_A3,
  input  logic [31:0] L_WD,
  input  logic [31:0] L_PC4,
  output logic        L_Ready,
  input  logic [4:0]  Q_A1,
  input  logic [4:0]  Q_A2,
  output logic        Q_Busy1,
  output logic        Q_Busy2,
  output logic        Hold,
  output logic        GRF_WE,
  output logic [4:0]  GRF_A3,
  output logic [31:0] GRF_WD,
  output logic [31:0] GRF_PC4,
  output logic        Dbg_State
);
  // Handshakes: a return transfers on a posedge where L_Valid && L_Ready; an issue is
  // accepted on a posedge where L_Issue && Issue_Ready. Ready never looks at same-cycle valid.
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {S_NORMAL = 1'b0, S_STARVED = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [4:0]     fa3_q  [FIFO_DEPTH];
  logic [31:0]    fwd_q  [FIFO_DEPTH];
  logic [31:0]    fpc_q  [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [OW-1:0]  out_q, out_d;
  logic [SW-1:0]  starve_q, starve_d;
  logic [31:0]    busy_q, busy_d;

  logic w_req, fifo_ne, head_grant, fifo_denied, enq, issue_acc;
  logic [4:0] head_a3;

  assign head_a3     = fa3_q[rd_ptr_q];
  assign w_req       = W_WE && (W_A3 != 5'd0) && !Reset;
  assign fifo_ne     = (cnt_q != '0);
  assign head_grant  = fifo_ne && !Reset && ((state_q == S_STARVED) || !w_req);
  assign fifo_denied = fifo_ne && !head_grant;
  assign L_Ready     = (cnt_q != CW'(FIFO_DEPTH));
  assign enq         = L_Valid && L_Ready && (L_A3 != 5'd0);
  assign Issue_Ready = (out_q < OW'(MAX_OUT));
  assign issue_acc   = L_Issue && Issue_Ready && (L_IssueA3 != 5'd0);

  assign Q_Busy1   = busy_q[Q_A1];
  assign Q_Busy2   = busy_q[Q_A2];
  assign Hold      = (state_q == S_STARVED) && !Reset;
  assign Dbg_State = state_q;

  always_comb begin
    GRF_WE  = 1'b0;
    GRF_A3  = 5'd0;
    GRF_WD  = 32'd0;
    GRF_PC4 = 32'd0;
    if (head_grant) begin
      GRF_WE  = 1'b1;
      GRF_A3  = head_a3;
      GRF_WD  = fwd_q[rd_ptr_q];
      GRF_PC4 = fpc_q[rd_ptr_q];
    end else if (w_req) begin
      GRF_WE  = 1'b1;
      GRF_A3  = W_A3;
      GRF_WD  = W_WD;
      GRF_PC4 = W_PC4;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    busy_d   = busy_q;
    case (state_q)
      S_NORMAL:  if (fifo_denied && (starve_q == SW'(STARVE_LIMIT - 1))) state_d = S_STARVED;
      S_STARVED: state_d = S_NORMAL;
      default:   state_d = S_NORMAL;
    endcase
    if (!fifo_ne || head_grant) starve_d = '0;
    else                        starve_d = starve_q + SW'(1);
    case ({enq, head_grant})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    case ({issue_acc, head_grant})
      2'b10:   out_d = out_q + OW'(1);
      2'b01:   out_d = out_q - OW'(1);
      default: out_d = out_q;
    endcase
    // Clear before set so a same-cycle re-issue of the drained register stays busy.
    if (head_grant) busy_d[head_a3]   = 1'b0;
    if (issue_acc)  busy_d[L_IssueA3] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_NORMAL;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      starve_q <= '0;
      busy_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fa3_q[i] <= 5'd0;
        fwd_q[i] <= 32'd0;
        fpc_q[i] <= 32'd0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      starve_q <= starve_d;
      busy_q   <= busy_d;
      if (enq) begin
        fa3_q[wr_ptr_q] <= L_A3;
        fwd_q[wr_ptr_q] <= L_WD;
        fpc_q[wr_ptr_q] <= L_PC4;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (head_grant) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end
endmodule

// File: tb/tb_grf_wport_arbiter.sv
// Directed bench for grf_wport_arbiter: inputs change 1 time unit after posedge,
// outputs are sampled a few units later, well clear of either clock edge.
module tb_grf_wport_arbiter;
  logic        Clk, Reset;
  logic        W_WE;
  logic [4:0]  W_A3;
  logic [31:0] W_WD, W_PC4;
  logic        L_Issue;
  logic [4:0]  L_IssueA3;
  logic        Issue_Ready;
  logic        L_Valid;
  logic [4:0]  L_A3;
  logic [31:0] L_WD, L_PC4;
  logic        L_Ready;
  logic [4:0]  Q_A1, Q_A2;
  logic        Q_Busy1, Q_Busy2, Hold;
  logic        GRF_WE;
  logic [4:0]  GRF_A3;
  logic [31:0] GRF_WD, GRF_PC4;
  logic        Dbg_State;

  int n_checks = 0;
  int n_fail   = 0;

  grf_wport_arbiter #(.FIFO_DEPTH(2), .MAX_OUT(4), .STARVE_LIMIT(3)) dut (
    .Clk(Clk), .Reset(Reset),
    .W_WE(W_WE), .W_A3(W_A3), .W_WD(W_WD), .W_PC4(W_PC4),
    .L_Issue(L_Issue), .L_IssueA3(L_IssueA3), .Issue_Ready(Issue_Ready),
    .L_Valid(L_Valid), .L_A3(L_A3), .L_WD(L_WD), .L_PC4(L_PC4), .L_Ready(L_Ready),
    .Q_A1(Q_A1), .Q_A2(Q_A2), .Q_Busy1(Q_Busy1), .Q_Busy2(Q_Busy2),
    .Hold(Hold), .GRF_WE(GRF_WE), .GRF_A3(GRF_A3), .GRF_WD(GRF_WD), .GRF_PC4(GRF_PC4),
    .Dbg_State(Dbg_State)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    W_WE = 1'b1; W_A3 = 5'd5; W_WD = 32'hAA; W_PC4 = 32'h0;
    L_Issue = 1'b0; L_IssueA3 = 5'd0;
    L_Valid = 1'b0; L_A3 = 5'd0; L_WD = 32'h0; L_PC4 = 32'h0;
    Q_A1 = 5'd0; Q_A2 = 5'd0;
    Reset = 1'b1;
    #12;
    check_eq("rst_grf_we", GRF_WE, 0);
    check_eq("rst_hold", Hold, 0);
    check_eq("rst_l_ready", L_Ready, 1);
    check_eq("rst_issue_ready", Issue_Ready, 1);
    check_eq("rst_busy1", Q_Busy1, 0);
    Reset = 1'b0;
    W_WE = 1'b0;
    tick();

    // W path is zero-latency
    W_WE = 1'b1; W_A3 = 5'd5; W_WD = 32'hAA; W_PC4 = 32'h44;
    #2;
    check_eq("t1_we", GRF_WE, 1);
    check_eq("t1_a3", GRF_A3, 5);
    check_eq("t1_wd", GRF_WD, 32'hAA);
    check_eq("t1_pc4", GRF_PC4, 32'h44);
    check_eq("t1_hold", Hold, 0);
    W_A3 = 5'd0;
    #2;
    check_eq("t1_r0_we", GRF_WE, 0);
    W_WE = 1'b0;

    // single long op to $8
    tick();
    L_Issue = 1'b1; L_IssueA3 = 5'd8; Q_A1 = 5'd8;
    #2;
    check_eq("t2_busy_pre", Q_Busy1, 0);
    tick();
    L_Issue = 1'b0;
    #2;
    check_eq("t2_busy_set", Q_Busy1, 1);
    tick();
    L_Valid = 1'b1; L_A3 = 5'd8; L_WD = 32'h12; L_PC4 = 32'h100;
    #2;
    check_eq("t2_accept_we", GRF_WE, 0);
    check_eq("t2_accept_rdy", L_Ready, 1);
    tick();
    L_Valid = 1'b0;
    #2;
    check_eq("t2_wr_we", GRF_WE, 1);
    check_eq("t2_wr_a3", GRF_A3, 8);
    check_eq("t2_wr_wd", GRF_WD, 32'h12);
    check_eq("t2_wr_pc4", GRF_PC4, 32'h100);
    check_eq("t2_wr_busy", Q_Busy1, 1);
    tick();
    #2;
    check_eq("t2_post_we", GRF_WE, 0);
    check_eq("t2_post_busy", Q_Busy1, 0);
    // issue to $0 is ignored
    tick();
    L_Issue = 1'b1; L_IssueA3 = 5'd0; Q_A2 = 5'd0;
    tick();
    L_Issue = 1'b0;
    #2;
    check_eq("t2_r0_busy", Q_Busy2, 0);

    // starvation guard
    tick();
    L_Issue = 1'b1; L_IssueA3 = 5'd9;
    tick();
    L_Issue = 1'b0;
    W_WE = 1'b1; W_A3 = 5'd5; W_WD = 32'h55;
    L_Valid = 1'b1; L_A3 = 5'd9; L_WD = 32'h33; L_PC4 = 32'h200;
    #2;
    check_eq("t3_a_a3", GRF_A3, 5);
    tick();
    L_Valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      check_eq("t3_w_a3", GRF_A3, 5);
      check_eq("t3_w_hold", Hold, 0);
      tick();
    end
    #2;
    check_eq("t3_hold", Hold, 1);
    check_eq("t3_state", Dbg_State, 1);
    check_eq("t3_head_we", GRF_WE, 1);
    check_eq("t3_head_a3", GRF_A3, 9);
    check_eq("t3_head_wd", GRF_WD, 32'h33);
    tick();
    #2;
    check_eq("t3_after_hold", Hold, 0);
    check_eq("t3_after_a3", GRF_A3, 5);
    check_eq("t3_after_wd", GRF_WD, 32'h55);
    W_WE = 1'b0;

    // FIFO full back-pressure and ordering
    for (int i = 0; i < 3; i++) begin
      tick();
      L_Issue = 1'b1; L_IssueA3 = 5'(10 + i);
    end
    tick();
    L_Issue = 1'b0;
    W_WE = 1'b1; W_A3 = 5'd5;
    L_Valid = 1'b1; L_A3 = 5'd10; L_WD = 32'hA0;
    #2;
    check_eq("t4_p_rdy", L_Ready, 1);
    check_eq("t4_p_a3", GRF_A3, 5);
    tick();
    L_A3 = 5'd11; L_WD = 32'hB0;
    #2;
    check_eq("t4_q_rdy", L_Ready, 1);
    check_eq("t4_q_a3", GRF_A3, 5);
    tick();
    W_WE = 1'b0;
    L_A3 = 5'd12; L_WD = 32'hC0;
    #2;
    check_eq("t4_full_rdy", L_Ready, 0);
    check_eq("t4_d0_we", GRF_WE, 1);
    check_eq("t4_d0_a3", GRF_A3, 10);
    check_eq("t4_d0_wd", GRF_WD, 32'hA0);
    tick();
    #2;
    check_eq("t4_s_rdy", L_Ready, 1);
    check_eq("t4_d1_a3", GRF_A3, 11);
    check_eq("t4_d1_wd", GRF_WD, 32'hB0);
    tick();
    L_Valid = 1'b0;
    #2;
    check_eq("t4_d2_we", GRF_WE, 1);
    check_eq("t4_d2_a3", GRF_A3, 12);
    check_eq("t4_d2_wd", GRF_WD, 32'hC0);
    tick();
    #2;
    check_eq("t4_idle_we", GRF_WE, 0);

    // outstanding limit
    for (int i = 0; i < 4; i++) begin
      tick();
      L_Issue = 1'b1; L_IssueA3 = 5'(13 + i);
      #2;
      check_eq("t5_issue_rdy", Issue_Ready, 1);
    end
    tick();
    L_IssueA3 = 5'd17; Q_A1 = 5'd17;
    #2;
    check_eq("t5_full", Issue_Ready, 0);
    tick();
    L_Issue = 1'b0; Q_A2 = 5'd16;
    #2;
    check_eq("t5_rej_busy", Q_Busy1, 0);
    check_eq("t5_busy16", Q_Busy2, 1);
    L_Valid = 1'b1; L_A3 = 5'd13; L_WD = 32'hD0;
    tick();
    L_Valid = 1'b0;
    #2;
    check_eq("t5_drain_a3", GRF_A3, 13);
    check_eq("t5_drain_rdy", Issue_Ready, 0);
    tick();
    #2;
    check_eq("t5_rdy_again", Issue_Ready, 1);

    // reset with two queued returns
    tick();
    W_WE = 1'b1; W_A3 = 5'd5;
    L_Valid = 1'b1; L_A3 = 5'd14; L_WD = 32'hE0;
    tick();
    L_A3 = 5'd15; L_WD = 32'hF0;
    tick();
    L_Valid = 1'b0; Q_A1 = 5'd14;
    #2;
    check_eq("t6_full", L_Ready, 0);
    check_eq("t6_busy_pre", Q_Busy1, 1);
    Reset = 1'b1;
    #1;
    check_eq("t6_rst_we", GRF_WE, 0);
    check_eq("t6_rst_busy1", Q_Busy1, 0);
    check_eq("t6_rst_busy2", Q_Busy2, 0);
    check_eq("t6_rst_hold", Hold, 0);
    check_eq("t6_rst_rdy", L_Ready, 1);
    check_eq("t6_rst_irdy", Issue_Ready, 1);
    tick();
    Reset = 1'b0; W_WE = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      #2;
      check_eq("t6_no_write", GRF_WE, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
